// File: rtl/cic_comp_fir.sv
// Serial-MAC FIR compensation filter for CIC droop; one shared multiplier over TAPS cycles.
// Accept -> out_valid after TAPS+2 cycles; in_ready only in IDLE, out held until out_ready.
module cic_comp_fir #(
  parameter int WIDTH  = 8,
  parameter int TAPS   = 4,
  parameter int COEF_W = 8,
  parameter int COEFS [TAPS] = '{-1, 9, 9, -1},
  parameter int SHIFT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int PW     = $clog2(TAPS);
  localparam int PROD_W = WIDTH + COEF_W + 1;
  localparam int ACC_W  = WIDTH + COEF_W + 1 + $clog2(TAPS);
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << WIDTH) - 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (SHIFT - 1));

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUTP} state_t;

  state_t                   state;
  logic [WIDTH-1:0]         dline [TAPS];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;

  logic signed [COEF_W-1:0] coef;
  logic signed [WIDTH:0]    samp;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic [WIDTH-1:0]         sat_val;
  logic [PW-1:0]            wr_next;
  logic [PW-1:0]            rd_prev;

  assign in_ready = (state == IDLE);

  // rd_ptr walks backwards from the newest sample, so k and rd_ptr track x[n-k]
  assign coef     = COEF_W'(COEFS[k]);
  assign samp     = {1'b0, dline[rd_ptr]};
  assign prod     = samp * coef;
  assign acc_next = acc + ACC_W'(prod);
  assign rounded  = acc + HALF;
  assign shifted  = rounded >>> SHIFT;
  assign wr_next  = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign rd_prev  = (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;

  always_comb begin
    sat_val = shifted[WIDTH-1:0];
    if (shifted < 0)
      sat_val = '0;
    else if (shifted > MAXV)
      sat_val = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      k         <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        dline[i] <= '0;
    end else begin
      if (in_valid && !in_ready)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dline[wr_ptr] <= in;
            rd_ptr        <= wr_ptr;
            wr_ptr        <= wr_next;
            k             <= '0;
            acc           <= '0;
            state         <= MAC;
          end
        end
        MAC: begin
          acc    <= acc_next;
          rd_ptr <= rd_prev;
          if (k == LAST)
            state <= ROUND;
          else
            k <= k + 1'b1;
        end
        ROUND: begin
          out       <= sat_val;
          out_valid <= 1'b1;
          state     <= OUTP;
        end
        OUTP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed + random bench for cic_comp_fir against a history-based FIR reference model.
module tb_cic_comp_fir;

  localparam int WIDTH = 8;
  localparam int TAPS  = 4;
  localparam int SHIFT = 4;
  localparam int C [TAPS] = '{-1, 9, 9, -1};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int hist[$];

  cic_comp_fir dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution over every accepted sample since reset.
  function automatic int model_out();
    int acc = 0;
    int v;
    for (int j = 0; j < TAPS; j++) begin
      int idx = hist.size() - 1 - j;
      if (idx >= 0) acc += C[j] * hist[idx];
    end
    v = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
    if (v < 0) v = 0;
    if (v > (1 << WIDTH) - 1) v = (1 << WIDTH) - 1;
    return v;
  endfunction

  // Send one sample, check latency/result, optionally stall out_ready or pulse an overrun.
  task automatic run_sample(input int s, input int hold, input bit pulse, input int exp_const);
    int cnt;
    int exp;
    int held;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in = WIDTH'(s);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    hist.push_back(s);
    exp = model_out();
    cnt = 1;
    while (!out_valid && cnt < 30) begin
      if (pulse && cnt == 2) begin
        in = 8'd200;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cnt), 32'd6);
    chk("out_vs_model", 32'(out), 32'(exp));
    if (exp_const >= 0) chk("out_vs_const", 32'(out), 32'(exp_const));
    held = out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_stable", 32'(out), 32'(held));
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_hs_out_valid", 32'(out_valid), 32'd0);
    chk("after_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int imp[5];
    int stp[6];
    imp = '{0, 9, 9, 0, 0};
    stp = '{0, 128, 255, 255, 255, 255};

    // Power-on reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Impulse with an overrun pulse during the second sample's MAC
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? 16 : 0, 0, i == 1, imp[i]);
      if (i >= 1) chk("overrun_sticky", 32'(overrun), 32'd1);
    end

    // Reset in the middle of a MAC, with in_valid held during reset
    in = 8'd50;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in = 8'd77;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    hist.delete();
    chk("midmac_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midmac_rst_out", 32'(out), 32'd0);
    chk("midmac_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midmac_rst_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++)
      run_sample((i == 0) ? 16 : 0, 0, 1'b0, imp[i]);

    // Step into saturation
    for (int i = 0; i < 6; i++)
      run_sample(255, 0, 1'b0, stp[i]);

    // Long downstream stall
    run_sample(100, 10, 1'b0, -1);

    // Wrap the delay line twice with a ramp
    for (int i = 1; i <= 9; i++)
      run_sample(i, 0, 1'b0, -1);

    // Random samples with random stalls
    for (int i = 0; i < 24; i++)
      run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, -1);

    chk("final_overrun_clear", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
